wb_master_bridge: RTL and testbench
===================================

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of BUSY cycles without wb_ack_i before the cycle is aborted (range 2..255).
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk input 1, the only clock; rst input 1, synchronous active-high reset.
REQ-003 SHALL have ports: cpu_ce_i input 1, request valid; cpu_we_i input 1, 1 = write; cpu_addr_i input 32, byte address; cpu_sel_i input 4, byte lanes; cpu_data_i input 32, write data.
REQ-004 SHALL have ports: cpu_data_o output 32, read data; stall_req_o output 1, hold pipeline; stall_i input 1, pipeline stalled by another source; flush_i input 1, abandon the current request.
REQ-005 SHALL have ports: wb_adr_o output 32; wb_dat_o output 32; wb_dat_i input 32; wb_we_o output 1; wb_sel_o output 4; wb_stb_o output 1; wb_cyc_o output 1; wb_ack_i input 1.
REQ-006 SHALL have port err_o output 1, a one-cycle pulse on timeout.

Function
REQ-007 SHALL implement FSM states IDLE, BUSY and WAIT_STALL.
REQ-008 In IDLE with cpu_ce_i=1 and flush_i=0, SHALL register wb_cyc_o=wb_stb_o=1, register adr/dat/we/sel from the cpu_* inputs, and enter BUSY on the next edge.
REQ-009 SHALL hold all wb_* outputs stable throughout BUSY.
REQ-010 In BUSY with wb_ack_i=1, SHALL clear cyc/stb/we/sel/adr/dat to 0 on the next edge.
  - On a read, SHALL latch wb_dat_i into rd_buf.
  - Next state SHALL be WAIT_STALL if stall_i=1, else IDLE.
REQ-011 In BUSY, SHALL count cycles without ack; at count TIMEOUT-1 it SHALL behave as an ack with rd_buf=0 and SHALL pulse err_o for 1 cycle.
REQ-012 The counter SHALL clear on entering BUSY.
REQ-013 In WAIT_STALL, SHALL go to IDLE when stall_i=0, otherwise hold.
REQ-014 flush_i=1 in any state SHALL force IDLE on the next edge, clear cyc/stb, and suppress the rd_buf update and err_o.
  - flush_i takes priority over ack and timeout in the same cycle.
REQ-015 stall_req_o (combinational) SHALL be 1 when in IDLE with cpu_ce_i=1 and flush_i=0, or when in BUSY with no ack, no timeout and flush_i=0; otherwise 0.
REQ-016 cpu_data_o SHALL equal wb_dat_i in BUSY when wb_ack_i=1 and cpu_we_i=0; otherwise it SHALL equal rd_buf.
REQ-017 Minimum latency SHALL be: request sampled at cycle N; stb high at N+1; ack at N+1 releases stall_req_o at N+1; the pipeline advances at edge N+2.
REQ-018 A new request SHALL NOT start in the cycle the bridge returns to IDLE; the earliest next stb is 2 cycles after the ack.
REQ-019 cpu_ce_i deasserting while in BUSY SHALL NOT abort the bus cycle; only flush_i aborts.
REQ-020 wb_ack_i seen outside BUSY SHALL be ignored.

Reset
REQ-021 rst=1 at a clk edge SHALL set state=IDLE, counter=0, rd_buf=0, all wb_* outputs=0 and err_o=0.
REQ-022 Reset SHALL take effect mid-transaction with no completion.
REQ-023 During reset, stall_req_o SHALL be 0.

Structure
REQ-024 Bus widths (WB_AddrBus, WB_DataBus, 4-bit select) and FSM state encodings SHALL come from the shared defines.v.
REQ-025 TIMEOUT SHALL stay local to the module.
REQ-026 The block SHALL be a single flat module with no sub-module.

Verification
REQ-027 Read: ce=1, we=0, addr=0x00000010, sel=0xF; ack at first BUSY cycle with wb_dat_i=0xDEADBEEF -> stb high exactly 1 cycle, cpu_data_o=0xDEADBEEF, stall_req_o low at the ack cycle.
REQ-028 Write with a 3-cycle ack delay: addr=0x00000104, data=0x12345678, sel=0x3 -> wb_* held constant for 3 cycles, we=1, stall_req_o=1 for 3 cycles then 0.
REQ-029 Ack while stall_i=1 for 2 more cycles -> FSM in WAIT_STALL, cpu_data_o holds the latched value, no new stb until stall_i=0.
REQ-030 No ack, TIMEOUT=16 -> cyc drops after 16 BUSY cycles, err_o pulses once, cpu_data_o=0.
REQ-031 flush_i in the same cycle as ack, and separately rst asserted mid-BUSY -> IDLE next cycle, cyc=0, rd_buf unchanged or 0 respectively, err_o=0.

Source files
------------

// File: rtl/wb_master_bridge_pkg.sv
// Shared bus widths and FSM state encoding for the Wishbone master bridge.
package wb_master_bridge_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BUSY       = 2'd1,
        ST_WAIT_STALL = 2'd2
    } state_e;

endpackage

// File: rtl/wb_master_bridge.sv
// Wishbone classic master bridge: turns a CPU pipeline memory request into a
// single Wishbone cycle, stalling the pipeline until ack, timeout or flush.
module wb_master_bridge
    import wb_master_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cpu_ce_i,
    input  logic                 cpu_we_i,
    input  logic [WB_ADDR_W-1:0] cpu_addr_i,
    input  logic [WB_SEL_W-1:0]  cpu_sel_i,
    input  logic [WB_DATA_W-1:0] cpu_data_i,
    output logic [WB_DATA_W-1:0] cpu_data_o,
    output logic                 stall_req_o,
    input  logic                 stall_i,
    input  logic                 flush_i,

    output logic [WB_ADDR_W-1:0] wb_adr_o,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    output logic                 wb_we_o,
    output logic [WB_SEL_W-1:0]  wb_sel_o,
    output logic                 wb_stb_o,
    output logic                 wb_cyc_o,
    input  logic                 wb_ack_i,
    output logic                 err_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e                 state_q;
    logic [7:0]             cnt_q;
    logic [WB_DATA_W-1:0]   rd_buf_q;
    logic [WB_ADDR_W-1:0]   adr_q;
    logic [WB_DATA_W-1:0]   dat_q;
    logic                   we_q;
    logic [WB_SEL_W-1:0]    sel_q;
    logic                   stb_q;
    logic                   cyc_q;
    logic                   err_q;

    logic                   busy_ack;
    logic                   busy_timeout;

    assign busy_ack     = (state_q == ST_BUSY) && wb_ack_i;
    assign busy_timeout = (state_q == ST_BUSY) && !wb_ack_i && (cnt_q == CNT_LAST);

    // Pipeline hold request: pending request in IDLE, or an unfinished bus cycle.
    always_comb begin
        stall_req_o = 1'b0;
        if (!rst && !flush_i) begin
            case (state_q)
                ST_IDLE: stall_req_o = cpu_ce_i;
                ST_BUSY: stall_req_o = !wb_ack_i && !busy_timeout;
                default: stall_req_o = 1'b0;
            endcase
        end
    end

    // Read data bypasses the buffer in the ack cycle so the pipeline can advance.
    always_comb begin
        cpu_data_o = rd_buf_q;
        if (busy_ack && !cpu_we_i) begin
            cpu_data_o = wb_dat_i;
        end
    end

    // Bridge FSM with registered Wishbone outputs; flush outranks ack and timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_buf_q <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (flush_i) begin
                state_q <= ST_IDLE;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cpu_ce_i) begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            adr_q   <= cpu_addr_i;
                            dat_q   <= cpu_data_i;
                            we_q    <= cpu_we_i;
                            sel_q   <= cpu_sel_i;
                            cnt_q   <= '0;
                            state_q <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (busy_ack || busy_timeout) begin
                            cyc_q <= 1'b0;
                            stb_q <= 1'b0;
                            we_q  <= 1'b0;
                            sel_q <= '0;
                            adr_q <= '0;
                            dat_q <= '0;
                            if (busy_ack) begin
                                if (!we_q) begin
                                    rd_buf_q <= wb_dat_i;
                                end
                            end else begin
                                rd_buf_q <= '0;
                                err_q    <= 1'b1;
                            end
                            state_q <= stall_i ? ST_WAIT_STALL : ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    ST_WAIT_STALL: begin
                        if (!stall_i) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = cyc_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: scenario tasks with a read-data
// scoreboard (expected data pushed at request time, popped at completion).
module tb_wb_master_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stall_req_o;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;
    logic        err_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_d;

    wb_master_bridge #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce_i    (cpu_ce_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_sel_i   (cpu_sel_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .stall_req_o (stall_req_o),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_ack_i    (wb_ack_i),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_sel_i = '0; cpu_data_i = '0;
        stall_i = 0; flush_i = 0; wb_ack_i = 0; wb_dat_i = '0;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic test_reset();
        rst = 1; cpu_ce_i = 1; cpu_sel_i = 4'hF; cpu_addr_i = 32'h44;
        @(negedge clk); #1;
        checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL reset_stall_req got %b want 0", stall_req_o); end
        checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb got %b%b want 00", wb_cyc_o, wb_stb_o); end
        checks++; if (wb_adr_o !== 32'h0 || wb_sel_o !== 4'h0 || wb_we_o !== 1'b0) begin errors++; $display("FAIL reset_wb got adr=%h sel=%h we=%b want 0", wb_adr_o, wb_sel_o, wb_we_o); end
        checks++; if (err_o !== 1'b0 || cpu_data_o !== 32'h0) begin errors++; $display("FAIL reset_err_data got err=%b data=%h want 0", err_o, cpu_data_o); end
        @(negedge clk); idle_inputs(); rst = 0;
        @(negedge clk);
    endtask

    task automatic test_read();
        @(negedge clk); cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h10; cpu_sel_i = 4'hF;
        sb_q.push_back(32'hDEADBEEF);
        #1;
        checks++; if (stall_req_o !== 1'b1 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL read_req got stall=%b stb=%b want 1 0", stall_req_o, wb_stb_o); end
        @(negedge clk); cpu_ce_i = 0; wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF; #1;
        exp_d = sb_q.pop_front();
        checks++; if (wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h10 || wb_sel_o !== 4'hF || wb_we_o !== 1'b0) begin errors++; $display("FAIL read_bus got stb=%b cyc=%b adr=%h sel=%h we=%b want 1 1 10 f 0", wb_stb_o, wb_cyc_o, wb_adr_o, wb_sel_o, wb_we_o); end
        checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL read_ack_stall got %b want 0", stall_req_o); end
        checks++; if (cpu_data_o !== exp_d) begin errors++; $display("FAIL read_bypass got %h want %h", cpu_data_o, exp_d); end
        @(negedge clk); wb_ack_i = 0; wb_dat_i = 32'h0; #1;
        checks++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || wb_adr_o !== 32'h0) begin errors++; $display("FAIL read_release got stb=%b cyc=%b adr=%h want 0 0 0", wb_stb_o, wb_cyc_o, wb_adr_o); end
        checks++; if (cpu_data_o !== exp_d) begin errors++; $display("FAIL read_rdbuf got %h want %h", cpu_data_o, exp_d); end
    endtask

    task automatic test_write_delay();
        @(negedge clk); cpu_ce_i = 1; cpu_we_i = 1; cpu_addr_i = 32'h104; cpu_data_i = 32'h12345678; cpu_sel_i = 4'h3;
        #1;
        checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL write_req_stall got %b want 1", stall_req_o); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); cpu_ce_i = 0; cpu_addr_i = 32'hFFFF_FFFF; cpu_data_i = 32'h0; #1;
            checks++; if (wb_adr_o !== 32'h104 || wb_dat_o !== 32'h12345678 || wb_sel_o !== 4'h3 || wb_we_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1) begin errors++; $display("FAIL write_hold[%0d] got adr=%h dat=%h sel=%h we=%b stb=%b", k, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o); end
            checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL write_stall[%0d] got %b want 1", k, stall_req_o); end
        end
        @(negedge clk); wb_ack_i = 1; wb_dat_i = 32'h5555AAAA; #1;
        checks++; if (stall_req_o !== 1'b0 || wb_stb_o !== 1'b1) begin errors++; $display("FAIL write_ack got stall=%b stb=%b want 0 1", stall_req_o, wb_stb_o); end
        checks++; if (cpu_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data_o got %h want deadbeef", cpu_data_o); end
        @(negedge clk); idle_inputs(); #1;
        checks++; if (wb_cyc_o !== 1'b0 || wb_we_o !== 1'b0 || wb_sel_o !== 4'h0 || wb_dat_o !== 32'h0) begin errors++; $display("FAIL write_clear got cyc=%b we=%b sel=%h dat=%h want 0", wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o); end
        checks++; if (cpu_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rdbuf_kept got %h want deadbeef", cpu_data_o); end
    endtask

    task automatic test_wait_stall();
        @(negedge clk); cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h20; cpu_sel_i = 4'hF;
        sb_q.push_back(32'hCAFEF00D);
        @(negedge clk); wb_ack_i = 1; wb_dat_i = 32'hCAFEF00D; stall_i = 1; #1;
        exp_d = sb_q.pop_front();
        checks++; if (cpu_data_o !== exp_d) begin errors++; $display("FAIL stall_ack_data got %h want %h", cpu_data_o, exp_d); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); wb_ack_i = (k == 1); wb_dat_i = 32'h11111111; #1;
            checks++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || stall_req_o !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d] got stb=%b cyc=%b stall=%b want 0", k, wb_stb_o, wb_cyc_o, stall_req_o); end
            checks++; if (cpu_data_o !== exp_d) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", k, cpu_data_o, exp_d); end
        end
        @(negedge clk); stall_i = 0; wb_ack_i = 0; cpu_ce_i = 0; #1;
        checks++; if (wb_stb_o !== 1'b0) begin errors++; $display("FAIL stall_release_stb got %b want 0", wb_stb_o); end
        @(negedge clk); #1;
        checks++; if (wb_stb_o !== 1'b0 || cpu_data_o !== exp_d) begin errors++; $display("FAIL stall_idle got stb=%b data=%h want 0 %h", wb_stb_o, cpu_data_o, exp_d); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        @(negedge clk); cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h40; cpu_sel_i = 4'hF;
        sb_q.push_back(32'h0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); cpu_ce_i = 0; #1;
            checks++; if (wb_cyc_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL timeout_busy[%0d] got cyc=%b err=%b want 1 0", i, wb_cyc_o, err_o); end
            checks++; if (stall_req_o !== (i < 16)) begin errors++; $display("FAIL timeout_stall[%0d] got %b want %b", i, stall_req_o, (i < 16)); end
        end
        @(negedge clk); #1;
        exp_d = sb_q.pop_front();
        checks++; if (wb_cyc_o !== 1'b0 || err_o !== 1'b1) begin errors++; $display("FAIL timeout_end got cyc=%b err=%b want 0 1", wb_cyc_o, err_o); end
        checks++; if (cpu_data_o !== exp_d) begin errors++; $display("FAIL timeout_data got %h want %h", cpu_data_o, exp_d); end
        @(negedge clk); #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", err_o); end
    endtask

    task automatic test_flush_ack();
        @(negedge clk); cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h28; cpu_sel_i = 4'hF;
        sb_q.push_back(32'hA5A55A5A);
        @(negedge clk); cpu_ce_i = 0; wb_ack_i = 1; wb_dat_i = 32'hA5A55A5A; #1;
        exp_d = sb_q.pop_front();
        checks++; if (cpu_data_o !== exp_d) begin errors++; $display("FAIL flush_pre_data got %h want %h", cpu_data_o, exp_d); end
        @(negedge clk); wb_ack_i = 0; cpu_ce_i = 1; cpu_addr_i = 32'h30;
        @(negedge clk); cpu_ce_i = 0; wb_ack_i = 1; flush_i = 1; wb_dat_i = 32'h77777777; #1;
        checks++; if (wb_stb_o !== 1'b1 || stall_req_o !== 1'b0) begin errors++; $display("FAIL flush_cycle got stb=%b stall=%b want 1 0", wb_stb_o, stall_req_o); end
        @(negedge clk); idle_inputs(); #1;
        checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL flush_after got cyc=%b stb=%b err=%b want 0", wb_cyc_o, wb_stb_o, err_o); end
        checks++; if (cpu_data_o !== exp_d) begin errors++; $display("FAIL flush_rdbuf got %h want %h", cpu_data_o, exp_d); end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk); cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h60; cpu_sel_i = 4'hF;
        @(negedge clk); cpu_ce_i = 0;
        @(negedge clk); rst = 1; wb_ack_i = 1; wb_dat_i = 32'h99999999; #1;
        checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL rst_busy_stall got %b want 0", stall_req_o); end
        @(negedge clk); rst = 0; idle_inputs(); #1;
        checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL rst_busy_bus got cyc=%b stb=%b err=%b want 0", wb_cyc_o, wb_stb_o, err_o); end
        checks++; if (cpu_data_o !== 32'h0) begin errors++; $display("FAIL rst_busy_rdbuf got %h want 0", cpu_data_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h50; cpu_sel_i = 4'hF;
        sb_q.push_back(32'h0BADF00D);
        @(negedge clk); cpu_addr_i = 32'h54; wb_ack_i = 1; wb_dat_i = 32'h0BADF00D; #1;
        exp_d = sb_q.pop_front();
        sb_q.push_back(32'h600DCAFE);
        checks++; if (wb_adr_o !== 32'h50 || cpu_data_o !== exp_d || stall_req_o !== 1'b0) begin errors++; $display("FAIL b2b_first got adr=%h data=%h stall=%b want 50 %h 0", wb_adr_o, cpu_data_o, stall_req_o, exp_d); end
        @(negedge clk); wb_ack_i = 0; wb_dat_i = 32'h0; #1;
        checks++; if (wb_stb_o !== 1'b0 || stall_req_o !== 1'b1) begin errors++; $display("FAIL b2b_gap got stb=%b stall=%b want 0 1", wb_stb_o, stall_req_o); end
        @(negedge clk); cpu_ce_i = 0; wb_ack_i = 1; wb_dat_i = 32'h600DCAFE; #1;
        exp_d = sb_q.pop_front();
        checks++; if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h54 || cpu_data_o !== exp_d) begin errors++; $display("FAIL b2b_second got stb=%b adr=%h data=%h want 1 54 %h", wb_stb_o, wb_adr_o, cpu_data_o, exp_d); end
        @(negedge clk); idle_inputs(); #1;
        checks++; if (wb_cyc_o !== 1'b0 || cpu_data_o !== exp_d) begin errors++; $display("FAIL b2b_end got cyc=%b data=%h want 0 %h", wb_cyc_o, cpu_data_o, exp_d); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_read();
        test_write_delay();
        test_wait_stall();
        test_timeout();
        test_flush_ack();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
